// File: rtl/key_debounce.sv
// Debounces one active-low pushbutton: clean level, press/release/long-press
// pulses and a press-toggled level, all registered.
module key_debounce #(
    parameter logic [26:0] DEB_TIME  = 27'd999999,
    parameter logic [26:0] LONG_TIME = 27'd49999999
) (
    input  logic CLK_50M,
    input  logic RST_N,
    input  logic KEY_N,
    output logic KEY_LEVEL,
    output logic KEY_PRESS,
    output logic KEY_RELEASE,
    output logic KEY_LONG,
    output logic KEY_TOGGLE
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] PRESS_DB   = 2'd1;
    localparam logic [1:0] PRESSED    = 2'd2;
    localparam logic [1:0] RELEASE_DB = 2'd3;

    logic        s1_q, s2_q;
    logic [1:0]  state_q, state_d;
    logic [26:0] dcnt_q, dcnt_d;
    logic [26:0] hcnt_q, hcnt_d;
    logic        level_q, level_d;
    logic        press_q, press_d;
    logic        release_q, release_d;
    logic        long_q, long_d;
    logic        toggle_q, toggle_d;

    // Synchronizer resets to 1 so a held key after reset still needs a full debounce.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= KEY_N;
            s2_q <= s1_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        hcnt_d    = hcnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        toggle_d  = toggle_q;
        case (state_q)
            IDLE: begin
                if (!s2_q) begin
                    state_d = PRESS_DB;
                    dcnt_d  = 27'd0;
                end
            end
            PRESS_DB: begin
                if (s2_q) begin
                    state_d = IDLE;
                end else if (dcnt_q == DEB_TIME) begin
                    state_d  = PRESSED;
                    press_d  = 1'b1;
                    toggle_d = ~toggle_q;
                    hcnt_d   = 27'd0;
                end else begin
                    dcnt_d = dcnt_q + 27'd1;
                end
            end
            PRESSED: begin
                if (s2_q) begin
                    state_d = RELEASE_DB;
                    dcnt_d  = 27'd0;
                end
            end
            default: begin
                // A bounce back low resumes the hold without clearing hcnt.
                if (!s2_q) begin
                    state_d = PRESSED;
                end else if (dcnt_q == DEB_TIME) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 27'd1;
                end
            end
        endcase
        if ((state_q == PRESSED || state_q == RELEASE_DB) && hcnt_q != LONG_TIME) begin
            hcnt_d = hcnt_q + 27'd1;
            long_d = (hcnt_q == LONG_TIME - 27'd1);
        end
        level_d = (state_d == PRESSED) || (state_d == RELEASE_DB);
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            dcnt_q    <= 27'd0;
            hcnt_q    <= 27'd0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            hcnt_q    <= hcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            toggle_q  <= toggle_d;
        end
    end

    assign KEY_LEVEL   = level_q;
    assign KEY_PRESS   = press_q;
    assign KEY_RELEASE = release_q;
    assign KEY_LONG    = long_q;
    assign KEY_TOGGLE  = toggle_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with DEB_TIME=4, LONG_TIME=20: expected
// pulse cycles are queued when a key sequence is driven and checked every cycle.
module tb_key_debounce;

    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int LAT  = DEB + 4;

    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_RELEASE = 2'd1;
    localparam logic [1:0] EV_LONG    = 2'd2;

    typedef struct {
        int         cyc;
        logic [1:0] kind;
    } ev_t;

    logic CLK_50M = 1'b0;
    logic RST_N   = 1'b0;
    logic KEY_N   = 1'b1;
    logic KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_LONG, KEY_TOGGLE;

    ev_t evq[$];
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;
    bit  exp_level  = 1'b0;
    bit  exp_toggle = 1'b0;

    key_debounce #(
        .DEB_TIME (27'd4),
        .LONG_TIME(27'd20)
    ) dut (
        .CLK_50M    (CLK_50M),
        .RST_N      (RST_N),
        .KEY_N      (KEY_N),
        .KEY_LEVEL  (KEY_LEVEL),
        .KEY_PRESS  (KEY_PRESS),
        .KEY_RELEASE(KEY_RELEASE),
        .KEY_LONG   (KEY_LONG),
        .KEY_TOGGLE (KEY_TOGGLE)
    );

    always #10 CLK_50M = ~CLK_50M;

    task automatic chk(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [1:0] k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        evq.push_back(e);
    endtask

    // Advance one edge, then compare every output against the queued schedule.
    task automatic tick();
        bit ep, er, el;
        ev_t e;
        @(posedge CLK_50M);
        cyc++;
        #1;
        ep = 1'b0; er = 1'b0; el = 1'b0;
        while (evq.size() > 0 && evq[0].cyc == cyc) begin
            e = evq.pop_front();
            case (e.kind)
                EV_PRESS:   begin ep = 1'b1; exp_level = 1'b1; exp_toggle = ~exp_toggle; end
                EV_RELEASE: begin er = 1'b1; exp_level = 1'b0; end
                default:    el = 1'b1;
            endcase
        end
        chk("press",   int'(KEY_PRESS),   int'(ep));
        chk("release", int'(KEY_RELEASE), int'(er));
        chk("long",    int'(KEY_LONG),    int'(el));
        chk("level",   int'(KEY_LEVEL),   int'(exp_level));
        chk("toggle",  int'(KEY_TOGGLE),  int'(exp_toggle));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Full press/release; optional release glitch (high 2, low 1, then high).
    task automatic press_seq(input int hold, input bit glitch);
        int c, rf;
        c  = cyc;
        rf = c + hold + (glitch ? 3 : 0);
        push(c + LAT, EV_PRESS);
        if (c + LAT + LONG <= rf + LAT) push(c + LAT + LONG, EV_LONG);
        push(rf + LAT, EV_RELEASE);
        KEY_N = 1'b0;
        ticks(hold);
        KEY_N = 1'b1;
        if (glitch) begin
            ticks(2);
            KEY_N = 1'b0;
            tick();
            KEY_N = 1'b1;
        end
        ticks(LAT + 6);
    endtask

    initial begin
        ticks(2);
        chk("rst_level",  int'(KEY_LEVEL),  0);
        chk("rst_toggle", int'(KEY_TOGGLE), 0);
        RST_N = 1'b1;
        ticks(3);

        // Bounce rejection: low 3, high 2, low 4, high 10.
        KEY_N = 1'b0; ticks(3);
        KEY_N = 1'b1; ticks(2);
        KEY_N = 1'b0; ticks(4);
        KEY_N = 1'b1; ticks(10);

        // Clean press held 40 cycles: one long pulse.
        press_seq(40, 1'b0);
        // Release with glitch.
        press_seq(12, 1'b1);
        // Two short presses: toggle returns to its prior value.
        press_seq(10, 1'b0);
        press_seq(10, 1'b0);
        // Long press released at hcnt=16: long fires inside release debounce.
        press_seq(LAT + 16, 1'b0);
        // Release lands exactly with long: both pulses in one cycle.
        press_seq(LONG, 1'b0);

        // Reset mid-hold with the key still down.
        begin
            int c;
            c = cyc;
            push(c + LAT, EV_PRESS);
            KEY_N = 1'b0;
            ticks(12);
            RST_N = 1'b0;
            #1;
            chk("async_level",  int'(KEY_LEVEL),  0);
            chk("async_toggle", int'(KEY_TOGGLE), 0);
            chk("async_long",   int'(KEY_LONG),   0);
            exp_level  = 1'b0;
            exp_toggle = 1'b0;
            ticks(3);
            RST_N = 1'b1;
            c = cyc;
            push(c + LAT, EV_PRESS);
            push(c + 15 + LAT, EV_RELEASE);
            ticks(15);
            KEY_N = 1'b1;
            ticks(LAT + 6);
        end

        chk("queue_empty", evq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
